// File: rtl/mpa_pkg.sv
// mpa_pkg: shared state encoding, depth derivation and pointer wrap helper for multi_port_array
package mpa_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction
  function automatic int next_ptr(input int idx, input int n);
    return idx + 1 >= n ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/multi_port_array_arb.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        grant = N'(1) << ((int'(ptr) + k) % N);
        idx = IW'((int'(ptr) + k) % N);
      end
  end
endmodule

// File: rtl/multi_port_array.sv
// multi_port_array: self-initialising shared array, NUM_PORTS reads, arbitrated write; MPA_WRITE_BYPASS_EN enables write-first forwarding
module multi_port_array
  import mpa_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rd_data,
  input  logic [NUM_PORTS-1:0]             wr_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wr_data,
  output logic [NUM_PORTS-1:0]             wr_grant,
  output logic                             init_busy
);
  localparam int DEPTH = depth(ADDR_WIDTH);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  state_t state;
  logic [ADDR_WIDTH-1:0] cnt, wa;
  logic [DATA_WIDTH-1:0] wd;
  logic [PW-1:0] ptr, gidx;
  logic [NUM_PORTS-1:0] arb_grant;
  logic run, wr_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_val [NUM_PORTS];
  rr_arbiter #(.N(NUM_PORTS)) u_arb (.req(wr_req), .ptr(ptr), .grant(arb_grant), .idx(gidx));
  assign run = state == ST_RUN && !reset;
  assign wr_grant = run ? arb_grant : '0;
  assign wr_en = |wr_grant;
  assign wa = wr_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign wd = wr_data[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign init_busy = !run;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
`ifdef MPA_WRITE_BYPASS_EN
    assign rd_val[g] = wr_en && rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH] == wa ? wd
                       : mem[rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH]];
`else
    assign rd_val[g] = mem[rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH]];
`endif
  end
  always_ff @(posedge clk)
    if (!reset) begin
      if (state == ST_INIT) mem[cnt] <= DATA_WIDTH'(cnt);
      else if (wr_en) mem[wa] <= wd;
    end
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_INIT;
      cnt <= '0;
      ptr <= '0;
      rd_data <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) state <= ST_RUN;
    end else begin
      if (wr_en) ptr <= PW'(next_ptr(int'(gidx), NUM_PORTS));
      for (int p = 0; p < NUM_PORTS; p++) rd_data[p*DATA_WIDTH +: DATA_WIDTH] <= rd_val[p];
    end
endmodule
